fctrl_sweep_bank: RTL and testbench

Multi-channel NCO frequency-control bank that replaces the single static step register feeding dsm_core.nco_step. The host writes per-channel shadow registers over a valid/ready config port. A global commit pulse atomically loads every channel, so all carriers change in the same cycle. Each channel either holds a fixed step (DIRECT) or runs a linear frequency sweep (RAMP) with programmable start, stop, delta, dwell and loop.

---
 rtl/fctrl_pkg.sv | 38 +++
 rtl/fctrl_ramp_ch.sv | 116 +++++++++++
 rtl/fctrl_sweep_bank.sv | 94 +++++++++
 tb/tb_fctrl_sweep_bank.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fctrl_pkg.sv
// rtl/fctrl_pkg.sv - shared types and register map for the NCO step bank
package fctrl_pkg;

    localparam int PKG_ACC_WIDTH   = 32;
    localparam int PKG_DWELL_WIDTH = 16;

    localparam logic [2:0] REG_START = 3'd0;
    localparam logic [2:0] REG_STOP  = 3'd1;
    localparam logic [2:0] REG_DELTA = 3'd2;
    localparam logic [2:0] REG_DWELL = 3'd3;
    localparam logic [2:0] REG_CTRL  = 3'd4;

    localparam int CTRL_MODE_BIT = 0;
    localparam int CTRL_LOOP_BIT = 1;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_RAMP   = 1'b1
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HOLD  = 3'd1,
        S_DWELL = 3'd2,
        S_STEP  = 3'd3,
        S_DONE  = 3'd4
    } ch_state_e;

    typedef struct packed {
        logic [PKG_ACC_WIDTH-1:0]   start;
        logic [PKG_ACC_WIDTH-1:0]   stop;
        logic [PKG_ACC_WIDTH-1:0]   delta;
        logic [PKG_DWELL_WIDTH-1:0] dwell;
        mode_e                      mode;
        logic                       loop;
    } ch_cfg_t;

endpackage

// File: rtl/fctrl_ramp_ch.sv
// rtl/fctrl_ramp_ch.sv - one NCO step channel: hold or linear sweep
module fctrl_ramp_ch
    import fctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     commit,
    input  ch_cfg_t                  cfg_in,
    output logic [PKG_ACC_WIDTH-1:0] step,
    output logic                     busy,
    output logic                     done
);

    localparam int AW = PKG_ACC_WIDTH;

    ch_cfg_t                    cfg_q, cfg_d;
    ch_state_e                  state_q, state_d;
    logic [AW-1:0]              step_q, step_d;
    logic [PKG_DWELL_WIDTH-1:0] cnt_q, cnt_d;
    // Set once the sweep has clamped to STOP in loop mode; the next STEP
    // wraps to START instead of moving further.
    logic                       at_end_q, at_end_d;

    logic [AW:0]   sum_w;
    logic [AW:0]   diff_w;
    logic [AW-1:0] nxt;
    logic          reach;

    // Next sweep value and whether it reaches, passes or wraps beyond STOP
    always_comb begin
        sum_w  = {1'b0, step_q} + {1'b0, cfg_q.delta};
        diff_w = {1'b0, step_q} - {1'b0, cfg_q.delta};
        nxt    = sum_w[AW-1:0];
        reach  = 1'b0;
        if (cfg_q.stop >= cfg_q.start) begin
            nxt   = sum_w[AW-1:0];
            reach = sum_w[AW] || (sum_w[AW-1:0] >= cfg_q.stop);
        end else begin
            nxt   = diff_w[AW-1:0];
            reach = diff_w[AW] || (diff_w[AW-1:0] <= cfg_q.stop);
        end
    end

    // Channel FSM: commit restarts from any state, otherwise dwell/step
    always_comb begin
        cfg_d    = cfg_q;
        state_d  = state_q;
        step_d   = step_q;
        cnt_d    = cnt_q;
        at_end_d = at_end_q;
        if (commit) begin
            cfg_d    = cfg_in;
            step_d   = cfg_in.start;
            cnt_d    = '0;
            at_end_d = 1'b0;
            if (cfg_in.mode == MODE_DIRECT) begin
                state_d = S_HOLD;
            end else if ((cfg_in.delta == '0) || (cfg_in.start == cfg_in.stop)) begin
                state_d = S_DONE;
            end else begin
                state_d = S_DWELL;
            end
        end else begin
            case (state_q)
                S_DWELL: begin
                    if (cnt_q == cfg_q.dwell) begin
                        cnt_d   = '0;
                        state_d = S_STEP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_STEP: begin
                    state_d = S_DWELL;
                    if (at_end_q) begin
                        step_d   = cfg_q.start;
                        at_end_d = 1'b0;
                    end else if (reach) begin
                        step_d = cfg_q.stop;
                        if (cfg_q.loop) begin
                            at_end_d = 1'b1;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        step_d = nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Channel state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q    <= '0;
            state_q  <= S_IDLE;
            step_q   <= '0;
            cnt_q    <= '0;
            at_end_q <= 1'b0;
        end else begin
            cfg_q    <= cfg_d;
            state_q  <= state_d;
            step_q   <= step_d;
            cnt_q    <= cnt_d;
            at_end_q <= at_end_d;
        end
    end

    assign step = step_q;
    assign busy = (state_q == S_DWELL) || (state_q == S_STEP);
    assign done = (state_q == S_DONE);

endmodule

// File: rtl/fctrl_sweep_bank.sv
// rtl/fctrl_sweep_bank.sv - multi-channel NCO step bank with shadow/commit
module fctrl_sweep_bank
    import fctrl_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int ACC_WIDTH   = PKG_ACC_WIDTH,
    parameter int DWELL_WIDTH = PKG_DWELL_WIDTH,
    parameter int CH_AW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
    input  logic                        clk_100mhz_mmcm_out,
    input  logic                        RST,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [CH_AW+2:0]            cfg_addr,
    input  logic [ACC_WIDTH-1:0]        cfg_data,
    output logic                        cfg_err,
    input  logic                        commit,
    output logic [NUM_CH*ACC_WIDTH-1:0] nco_step,
    output logic [NUM_CH-1:0]           busy,
    output logic [NUM_CH-1:0]           done
);

    localparam logic [CH_AW:0] NUM_CH_W = (CH_AW+1)'(NUM_CH);

    ch_cfg_t shadow_q [NUM_CH];
    ch_cfg_t shadow_d [NUM_CH];
    logic    cfg_ready_q, cfg_ready_d;
    logic    cfg_err_q, cfg_err_d;

    logic [CH_AW-1:0] addr_ch;
    logic [2:0]       addr_reg;
    logic             wr_fire;
    logic             addr_ok;

    assign addr_ch  = cfg_addr[CH_AW+2:3];
    assign addr_reg = cfg_addr[2:0];
    assign wr_fire  = cfg_valid & cfg_ready_q;
    assign addr_ok  = (addr_reg <= REG_CTRL) && ({1'b0, addr_ch} < NUM_CH_W);

    // Config decode into the shadow array; illegal addresses only raise cfg_err
    always_comb begin
        cfg_ready_d = 1'b1;
        cfg_err_d   = wr_fire & ~addr_ok;
        for (int k = 0; k < NUM_CH; k++) begin
            shadow_d[k] = shadow_q[k];
            if (wr_fire && addr_ok && (addr_ch == CH_AW'(k))) begin
                case (addr_reg)
                    REG_START: shadow_d[k].start = cfg_data;
                    REG_STOP:  shadow_d[k].stop  = cfg_data;
                    REG_DELTA: shadow_d[k].delta = cfg_data;
                    REG_DWELL: shadow_d[k].dwell = cfg_data[DWELL_WIDTH-1:0];
                    default: begin
                        shadow_d[k].mode = mode_e'(cfg_data[CTRL_MODE_BIT]);
                        shadow_d[k].loop = cfg_data[CTRL_LOOP_BIT];
                    end
                endcase
            end
        end
    end

    // Shadow registers and config handshake flops
    always_ff @(posedge clk_100mhz_mmcm_out) begin
        if (RST) begin
            cfg_ready_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            cfg_ready_q <= cfg_ready_d;
            cfg_err_q   <= cfg_err_d;
            for (int k = 0; k < NUM_CH; k++) begin
                shadow_q[k] <= shadow_d[k];
            end
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign cfg_err   = cfg_err_q;

    // Commit samples shadow_q before any same-cycle write lands in it
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        fctrl_ramp_ch u_ch (
            .clk    (clk_100mhz_mmcm_out),
            .rst    (RST),
            .commit (commit),
            .cfg_in (shadow_q[k]),
            .step   (nco_step[k*ACC_WIDTH +: ACC_WIDTH]),
            .busy   (busy[k]),
            .done   (done[k])
        );
    end

endmodule

// File: tb/tb_fctrl_sweep_bank.sv
// tb/tb_fctrl_sweep_bank.sv - directed self-checking bench for fctrl_sweep_bank
module tb_fctrl_sweep_bank;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        cfg_err;
    logic        commit;
    logic [63:0] nco_step;
    logic [1:0]  busy;
    logic [1:0]  done;

    int n_checks = 0;
    int n_fail   = 0;

    fctrl_sweep_bank #(.NUM_CH(2)) dut (
        .clk_100mhz_mmcm_out (clk),
        .RST                 (rst),
        .cfg_valid           (cfg_valid),
        .cfg_ready           (cfg_ready),
        .cfg_addr            (cfg_addr),
        .cfg_data            (cfg_data),
        .cfg_err             (cfg_err),
        .commit              (commit),
        .nco_step            (nco_step),
        .busy                (busy),
        .done                (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] addr, input logic [31:0] data);
        cfg_valid = 1'b1;
        cfg_addr  = addr;
        cfg_data  = data;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_ready got %0b want 0", cfg_ready); end
        n_checks++;
        if (nco_step !== 64'd0) begin n_fail++; $display("FAIL reset_nco_step got %h want 0", nco_step); end
        n_checks++;
        if (busy !== 2'b00 || done !== 2'b00 || cfg_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got busy=%b done=%b err=%b want 00 00 0", busy, done, cfg_err);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset got %0b want 1", cfg_ready); end
    endtask

    task automatic test_direct();
        cfg_write(4'b0_000, 32'h0147AE14);
        cfg_write(4'b0_100, 32'h0);
        n_checks++;
        if (nco_step[31:0] !== 32'h0) begin n_fail++; $display("FAIL direct_pre_commit got %h want 0", nco_step[31:0]); end
        do_commit();
        n_checks++;
        if (nco_step[31:0] !== 32'h0147AE14) begin n_fail++; $display("FAIL direct_step got %h want 0147ae14", nco_step[31:0]); end
        n_checks++;
        if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin n_fail++; $display("FAIL direct_flags got busy=%b done=%b want 0 0", busy[0], done[0]); end
        n_checks++;
        if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL direct_no_err got %b want 0", cfg_err); end
    endtask

    // Ramp vectors on channel 1: start, stop, delta, dwell, expected sequence
    logic [31:0] tv_start [5] = '{32'd100, 32'd100, 32'd130, 32'h10, 32'd0};
    logic [31:0] tv_stop  [5] = '{32'd130, 32'd125, 32'd100, 32'h0,  32'd3};
    logic [31:0] tv_delta [5] = '{32'd10,  32'd10,  32'd10,  32'h20, 32'd1};
    logic [31:0] tv_dwell [5] = '{32'd1,   32'd1,   32'd1,   32'd1,  32'd0};
    int          tv_n     [5] = '{4, 4, 4, 2, 4};
    logic [31:0] tv_exp   [5][4] = '{
        '{32'd100, 32'd110, 32'd120, 32'd130},
        '{32'd100, 32'd110, 32'd120, 32'd125},
        '{32'd130, 32'd120, 32'd110, 32'd100},
        '{32'h10,  32'h0,   32'h0,   32'h0},
        '{32'd0,   32'd1,   32'd2,   32'd3}
    };

    task automatic test_ramps();
        for (int v = 0; v < 5; v++) begin
            cfg_write(4'b1_000, tv_start[v]);
            cfg_write(4'b1_001, tv_stop[v]);
            cfg_write(4'b1_010, tv_delta[v]);
            cfg_write(4'b1_011, tv_dwell[v]);
            cfg_write(4'b1_100, 32'd1);
            do_commit();
            for (int i = 0; i < tv_n[v] - 1; i++) begin
                for (int c = 0; c < int'(tv_dwell[v]) + 2; c++) begin
                    n_checks++;
                    if (nco_step[63:32] !== tv_exp[v][i] || busy[1] !== 1'b1 || done[1] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL ramp%0d_val%0d_cyc%0d got step=%0d busy=%b done=%b want step=%0d busy=1 done=0",
                                 v, i, c, nco_step[63:32], busy[1], done[1], tv_exp[v][i]);
                    end
                    tick();
                end
            end
            n_checks++;
            if (nco_step[63:32] !== tv_exp[v][tv_n[v]-1] || busy[1] !== 1'b0 || done[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL ramp%0d_final got step=%0d busy=%b done=%b want step=%0d busy=0 done=1",
                         v, nco_step[63:32], busy[1], done[1], tv_exp[v][tv_n[v]-1]);
            end
            repeat (5) tick();
            n_checks++;
            if (nco_step[63:32] !== tv_exp[v][tv_n[v]-1] || done[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL ramp%0d_hold got step=%0d done=%b want step=%0d done=1",
                         v, nco_step[63:32], done[1], tv_exp[v][tv_n[v]-1]);
            end
        end
    endtask

    task automatic test_loop_atomic();
        logic [31:0] pat [3] = '{32'd0, 32'd10, 32'd20};
        logic [31:0] e;
        int k;
        cfg_write(4'b0_000, 32'd0);
        cfg_write(4'b0_001, 32'd20);
        cfg_write(4'b0_010, 32'd10);
        cfg_write(4'b0_011, 32'd1);
        cfg_write(4'b0_100, 32'd3);
        cfg_write(4'b1_000, 32'd77);
        cfg_write(4'b1_100, 32'd0);
        do_commit();
        k = 0;
        for (int i = 0; i < 20; i++) begin
            e = pat[(k / 3) % 3];
            n_checks++;
            if (nco_step[31:0] !== e || done[0] !== 1'b0 || nco_step[63:32] !== 32'd77) begin
                n_fail++;
                $display("FAIL loop_cyc%0d got ch0=%0d done0=%b ch1=%0d want ch0=%0d done0=0 ch1=77",
                         k, nco_step[31:0], done[0], nco_step[63:32], e);
            end
            tick();
            k++;
        end
        cfg_write(4'b0_000, 32'd5);
        cfg_write(4'b1_000, 32'd200);
        cfg_write(4'b1_100, 32'd0);
        k += 2;
        e = pat[(k / 3) % 3];
        n_checks++;
        if (nco_step[31:0] !== e || nco_step[63:32] !== 32'd77) begin
            n_fail++;
            $display("FAIL shadow_no_disturb got ch0=%0d ch1=%0d want ch0=%0d ch1=77", nco_step[31:0], nco_step[63:32], e);
        end
        do_commit();
        n_checks++;
        if (nco_step[31:0] !== 32'd5 || nco_step[63:32] !== 32'd200) begin
            n_fail++;
            $display("FAIL atomic_commit got ch0=%0d ch1=%0d want ch0=5 ch1=200", nco_step[31:0], nco_step[63:32]);
        end
    endtask

    task automatic test_boundary();
        cfg_write(4'b0_110, 32'hDEAD);
        n_checks++;
        if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfg_err_pulse got %b want 1", cfg_err); end
        tick();
        n_checks++;
        if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_err_clear got %b want 0", cfg_err); end
        do_commit();
        n_checks++;
        if (nco_step[31:0] !== 32'd5) begin n_fail++; $display("FAIL bad_addr_shadow got %0d want 5", nco_step[31:0]); end

        cfg_write(4'b1_000, 32'd250);
        cfg_valid = 1'b1;
        cfg_addr  = 4'b1_000;
        cfg_data  = 32'd300;
        commit    = 1'b1;
        tick();
        cfg_valid = 1'b0;
        commit    = 1'b0;
        n_checks++;
        if (nco_step[63:32] !== 32'd250) begin n_fail++; $display("FAIL write_commit_same got %0d want 250", nco_step[63:32]); end
        do_commit();
        n_checks++;
        if (nco_step[63:32] !== 32'd300) begin n_fail++; $display("FAIL write_commit_next got %0d want 300", nco_step[63:32]); end

        cfg_write(4'b1_000, 32'd50);
        cfg_write(4'b1_001, 32'd90);
        cfg_write(4'b1_010, 32'd0);
        cfg_write(4'b1_011, 32'd0);
        cfg_write(4'b1_100, 32'd1);
        do_commit();
        n_checks++;
        if (nco_step[63:32] !== 32'd50 || done[1] !== 1'b1 || busy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL delta_zero got step=%0d done=%b busy=%b want 50 1 0", nco_step[63:32], done[1], busy[1]);
        end

        repeat (3) tick();
        n_checks++;
        if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL pre_rst_busy got %b want 1", busy[0]); end
        rst = 1'b1;
        tick();
        n_checks++;
        if (nco_step !== 64'd0 || busy !== 2'b00 || done !== 2'b00 || cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_ramp got step=%h busy=%b done=%b ready=%b want 0 00 00 0", nco_step, busy, done, cfg_ready);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (cfg_ready !== 1'b1 || nco_step !== 64'd0) begin
            n_fail++;
            $display("FAIL post_rst got ready=%b step=%h want 1 0", cfg_ready, nco_step);
        end
    endtask

    initial begin
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        commit    = 1'b0;
        test_reset();
        test_direct();
        test_ramps();
        test_loop_atomic();
        test_boundary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
